// File: rtl/motor_array.sv
`default_nettype none
//==============================================================================
// Module   : motor_array
// Brief    : N-channel motor I/O: x4 quadrature decode (position, velocity,
//            fault) and glitch-free PWM with a valid/ready duty write port.
//            Define MOTOR_ARRAY_WDOG_EN to zero duties that go stale.
// Revision : 1.0 - initial release
//==============================================================================
module motor_array #(
    parameter int NCH        = 2,
    parameter int QEI_RES    = 16,
    parameter int PWM_RES    = 10,
    parameter int PWM_DIV    = 4,
    parameter int SAMPLE_DIV = 48000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NCH-1:0]           qei_a,
    input  logic [NCH-1:0]           qei_b,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_ch,
    input  logic [PWM_RES-1:0]       wr_duty,
    output logic [NCH*QEI_RES-1:0]   pos,
    output logic [NCH*QEI_RES-1:0]   vel,
    output logic                     vel_valid,
    output logic [NCH-1:0]           pwm,
    output logic [NCH-1:0]           fault
);

    localparam int         c_PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int         c_SMP_W = $clog2(SAMPLE_DIV);
    localparam logic [3:0] c_NCH   = 4'(NCH);

    logic                r_rstDone;
    logic [c_SMP_W-1:0]  r_smpCnt;
    logic                w_smpTick;
    logic                r_velValid;
    logic [c_PRE_W-1:0]  r_pwmPre;
    logic [PWM_RES-1:0]  r_pwmCnt;
    logic                w_pwmStep;
    logic                w_boundary;
    logic [NCH-1:0]      w_pendValid;
    logic [7:0]          w_pendPad;
    logic                w_chValid;
    logic                w_accept;

    assign w_smpTick = (r_smpCnt == c_SMP_W'(SAMPLE_DIV - 1));
    assign vel_valid = r_velValid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstDone  <= 1'b0;
            r_smpCnt   <= '0;
            r_velValid <= 1'b0;
        end else begin
            r_rstDone  <= 1'b1;
            r_velValid <= w_smpTick;
            r_smpCnt   <= w_smpTick ? '0 : r_smpCnt + c_SMP_W'(1);
        end
    end

    // The PWM timebase freezes while disabled so the period resumes in phase
    assign w_pwmStep  = en && (r_pwmPre == c_PRE_W'(PWM_DIV - 1));
    assign w_boundary = w_pwmStep && (r_pwmCnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwmPre <= '0;
            r_pwmCnt <= '0;
        end else if (en) begin
            r_pwmPre <= w_pwmStep ? '0 : r_pwmPre + c_PRE_W'(1);
            if (w_pwmStep) begin
                r_pwmCnt <= r_pwmCnt + PWM_RES'(1);
            end
        end
    end

    always_comb begin
        w_pendPad            = '0;
        w_pendPad[NCH-1:0]   = w_pendValid;
    end

    // Writes to absent channels are always accepted and dropped
    assign w_chValid = ({1'b0, wr_ch} < c_NCH);
    assign wr_ready  = r_rstDone && (!w_chValid || !w_pendPad[wr_ch]);
    assign w_accept  = wr_valid && wr_ready && w_chValid;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]          r_sync1;
        logic [1:0]          r_sync2;
        logic [1:0]          r_abPrev;
        logic [1:0]          w_step;
        logic [QEI_RES-1:0]  r_pos;
        logic [QEI_RES-1:0]  r_posPrev;
        logic [QEI_RES-1:0]  r_vel;
        logic                r_fault;
        logic                r_pend;
        logic                r_pwm;
        logic [PWM_RES-1:0]  r_pendDuty;
        logic [PWM_RES-1:0]  r_duty;
        logic                w_wrSel;
        logic                w_expired;

        // Gray phase index is {A, A^B}; the mod-4 phase difference is the step
        assign w_step  = {r_sync2[1], ^r_sync2} - {r_abPrev[1], ^r_abPrev};
        assign w_wrSel = w_accept && (wr_ch == 3'(i));

`ifdef MOTOR_ARRAY_WDOG_EN
        logic [3:0] r_wdCnt;

        assign w_expired = r_wdCnt[3];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wdCnt <= '0;
            end else if (w_wrSel) begin
                r_wdCnt <= '0;
            end else if (w_smpTick && !r_wdCnt[3]) begin
                r_wdCnt <= r_wdCnt + 4'd1;
            end
        end
`else
        assign w_expired = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1   <= '0;
                r_sync2   <= '0;
                r_abPrev  <= '0;
                r_pos     <= '0;
                r_posPrev <= '0;
                r_vel     <= '0;
                r_fault   <= 1'b0;
            end else begin
                r_sync1  <= {qei_a[i], qei_b[i]};
                r_sync2  <= r_sync1;
                r_abPrev <= r_sync2;
                case (w_step)
                    2'b01:   r_pos   <= r_pos + QEI_RES'(1);
                    2'b11:   r_pos   <= r_pos - QEI_RES'(1);
                    2'b10:   r_fault <= 1'b1;
                    default: ;
                endcase
                if (w_smpTick) begin
                    r_vel     <= r_pos - r_posPrev;
                    r_posPrev <= r_pos;
                end
            end
        end

        // Boundary consumes the old pending value before a same-cycle write
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pend     <= 1'b0;
                r_pendDuty <= '0;
                r_duty     <= '0;
                r_pwm      <= 1'b0;
            end else begin
                if (w_boundary) begin
                    if (w_expired) begin
                        r_duty <= '0;
                        r_pend <= 1'b0;
                    end else if (r_pend) begin
                        r_duty <= r_pendDuty;
                        r_pend <= 1'b0;
                    end
                end
                if (w_wrSel) begin
                    r_pendDuty <= wr_duty;
                    r_pend     <= 1'b1;
                end
                r_pwm <= en && (r_pwmCnt < r_duty);
            end
        end

        assign pos[i*QEI_RES +: QEI_RES] = r_pos;
        assign vel[i*QEI_RES +: QEI_RES] = r_vel;
        assign pwm[i]                    = r_pwm;
        assign fault[i]                  = r_fault;
        assign w_pendValid[i]            = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_array.sv
`default_nettype none
//==============================================================================
// Module   : tb_motor_array
// Brief    : Randomized self-checking bench for motor_array against a
//            cycle-counting reference model; covers MOTOR_ARRAY_WDOG_EN too.
// Revision : 1.0 - initial release
//==============================================================================
module tb_motor_array;

    localparam int NCH        = 2;
    localparam int QEI_RES    = 16;
    localparam int PWM_RES    = 10;
    localparam int PWM_DIV    = 4;
    localparam int SAMPLE_DIV = 2000;
    localparam int CMAX       = (1 << PWM_RES);
    localparam int PERIOD     = CMAX * PWM_DIV;

    logic                    clk      = 1'b0;
    logic                    rst      = 1'b0;
    logic                    en       = 1'b0;
    logic [NCH-1:0]          qei_a    = '0;
    logic [NCH-1:0]          qei_b    = '0;
    logic                    wr_valid = 1'b0;
    logic [2:0]              wr_ch    = '0;
    logic [PWM_RES-1:0]      wr_duty  = '0;
    logic                    wr_ready;
    logic [NCH*QEI_RES-1:0]  pos;
    logic [NCH*QEI_RES-1:0]  vel;
    logic                    vel_valid;
    logic [NCH-1:0]          pwm;
    logic [NCH-1:0]          fault;

    motor_array #(
        .NCH        (NCH),
        .QEI_RES    (QEI_RES),
        .PWM_RES    (PWM_RES),
        .PWM_DIV    (PWM_DIV),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .qei_a     (qei_a),
        .qei_b     (qei_b),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ch     (wr_ch),
        .wr_duty   (wr_duty),
        .pos       (pos),
        .vel       (vel),
        .vel_valid (vel_valid),
        .pwm       (pwm),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]          hist [NCH][3];
    logic [QEI_RES-1:0]  mPos [NCH];
    logic [QEI_RES-1:0]  mPrev [NCH];
    logic [QEI_RES-1:0]  mVel [NCH];
    logic                mFault [NCH];
    logic                mPend [NCH];
    logic                mPwm [NCH];
    logic [PWM_RES-1:0]  mDuty [NCH];
    logic [PWM_RES-1:0]  mPendDuty [NCH];
    int                  mWd [NCH];
    logic                mVv, mRdy;
    int                  mEdge, mEnEdges;
    bit                  mTick, mBnd, mAcc;
    int                  mCntB, mDir, mWi;

    function automatic int phaseOf(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] grayOf(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < 3; k++) hist[ch][k] = 2'b00;
                mPos[ch] = '0; mPrev[ch] = '0; mVel[ch] = '0;
                mFault[ch] = 1'b0; mPend[ch] = 1'b0; mPwm[ch] = 1'b0;
                mDuty[ch] = '0; mPendDuty[ch] = '0; mWd[ch] = 0;
            end
            mVv = 1'b0; mRdy = 1'b0; mEdge = 0; mEnEdges = 0;
        end else begin
            mEdge++;
            mTick = (mEdge % SAMPLE_DIV) == 0;
            mWi   = int'(wr_ch);
            mAcc  = mRdy && wr_valid && ((mWi >= NCH) ? 1'b1 : !mPend[mWi]);
            mCntB = (mEnEdges / PWM_DIV) % CMAX;
            mBnd  = en && ((mEnEdges % PWM_DIV) == PWM_DIV - 1) && (mCntB == CMAX - 1);
            for (int ch = 0; ch < NCH; ch++) begin
                if (mTick) begin
                    mVel[ch]  = mPos[ch] - mPrev[ch];
                    mPrev[ch] = mPos[ch];
                end
                mDir = (phaseOf(hist[ch][1]) - phaseOf(hist[ch][2]) + 4) % 4;
                if (mDir == 1)      mPos[ch] = mPos[ch] + 1'b1;
                else if (mDir == 3) mPos[ch] = mPos[ch] - 1'b1;
                else if (mDir == 2) mFault[ch] = 1'b1;
                hist[ch][2] = hist[ch][1];
                hist[ch][1] = hist[ch][0];
                hist[ch][0] = {qei_a[ch], qei_b[ch]};
                mPwm[ch] = en && (mCntB < int'(mDuty[ch]));
                if (mBnd) begin
`ifdef MOTOR_ARRAY_WDOG_EN
                    if (mWd[ch] >= 8) begin
                        mDuty[ch] = '0;
                        mPend[ch] = 1'b0;
                    end else
`endif
                    if (mPend[ch]) begin
                        mDuty[ch] = mPendDuty[ch];
                        mPend[ch] = 1'b0;
                    end
                end
                if (mAcc && mWi == ch) begin
                    mPendDuty[ch] = wr_duty;
                    mPend[ch]     = 1'b1;
                    mWd[ch]       = 0;
                end else if (mTick && mWd[ch] < 8) begin
                    mWd[ch]++;
                end
            end
            mVv  = mTick;
            mRdy = 1'b1;
            if (en) mEnEdges++;
        end
    end

    logic [NCH*QEI_RES-1:0] ePos, eVel;
    logic [NCH-1:0]         ePwm, eFault;
    logic                   eRdy;

    always @(negedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                ePos[ch*QEI_RES +: QEI_RES] = mPos[ch];
                eVel[ch*QEI_RES +: QEI_RES] = mVel[ch];
                ePwm[ch]   = mPwm[ch];
                eFault[ch] = mFault[ch];
            end
            mWi  = int'(wr_ch);
            eRdy = mRdy && ((mWi >= NCH) ? 1'b1 : !mPend[mWi]);
            check("pos", pos, ePos);
            check("vel", vel, eVel);
            check("vel_valid", vel_valid, mVv);
            check("pwm", pwm, ePwm);
            check("fault", fault, eFault);
            check("wr_ready", wr_ready, eRdy);
        end
    end

    // ---------------- stimulus ----------------
    int ph [NCH];
    int hi, r, c;
    bit seen;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic setStep(input int ch, input int dir);
        logic [1:0] ab;
        ph[ch] = (ph[ch] + dir + 4) % 4;
        ab = grayOf(ph[ch]);
        qei_a[ch] = ab[1];
        qei_b[ch] = ab[0];
    endtask

    task automatic qstep(input int ch, input int dir);
        setStep(ch, dir);
        cyc(10);
    endtask

    task automatic waitVv();
        seen = 1'b0;
        for (int i = 0; i < SAMPLE_DIV + 20 && !seen; i++) begin
            @(negedge clk);
            if (vel_valid) seen = 1'b1;
        end
        if (!seen) check("vel_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic countHigh(input int ch);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm[ch]) hi++;
        end
    endtask

    task automatic waitReady();
        seen = 1'b0;
        for (int i = 0; i < PERIOD + 20 && !seen; i++) begin
            @(negedge clk);
            if (wr_ready) seen = 1'b1;
        end
        if (!seen) check("wr_ready_timeout", 1'b0, 1'b1);
        cyc(1);
    endtask

    initial begin
        for (int ch = 0; ch < NCH; ch++) ph[ch] = 0;
        cyc(3);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_pwm", pwm, '0);
        rst = 1'b1;
        en  = 1'b1;
        cyc(1);
        check("init_wr_ready", wr_ready, 1'b1);
        check("init_pos", pos, '0);
        check("init_vel", vel, '0);
        check("init_fault", fault, '0);

        repeat (4) qstep(0, 1);
        check("fwd_pos0", pos[QEI_RES-1:0], 16'd4);
        check("fwd_pos1", pos[2*QEI_RES-1:QEI_RES], 16'd0);
        repeat (6) qstep(0, -1);
        check("rev_pos0", pos[QEI_RES-1:0], 16'hFFFE);

        qei_a[1] = 1'b1;
        qei_b[1] = 1'b1;
        ph[1] = 2;
        cyc(10);
        check("illegal_fault1", fault[1], 1'b1);
        check("illegal_pos1", pos[2*QEI_RES-1:QEI_RES], 16'd0);
        qstep(1, 1);
        check("sticky_fault1", fault[1], 1'b1);
        check("legal_pos1", pos[2*QEI_RES-1:QEI_RES], 16'd1);

        seen = 1'b0;
        for (int i = 0; i < PERIOD + 10 && !seen; i++) begin
            if (((mEnEdges / PWM_DIV) % CMAX) == 300) seen = 1'b1;
            else cyc(1);
        end
        if (!seen) check("cnt_mid_timeout", 1'b0, 1'b1);
        wr_ch = 3'd0; wr_duty = 10'd512; wr_valid = 1'b1;
        @(negedge clk);
        check("wr0_ready", wr_ready, 1'b1);
        cyc(1);
        wr_duty = 10'd100;
        @(negedge clk);
        check("wr0_busy", wr_ready, 1'b0);
        check("pwm0_before_wrap", pwm[0], 1'b0);
        cyc(1);
        wr_valid = 1'b0;
        cyc(PERIOD + 10);
        countHigh(0);
        check("pwm0_high_cycles", hi, 512 * PWM_DIV);

        qstep(0, -1);
        waitVv();
        check("pos0_fffd", pos[QEI_RES-1:0], 16'hFFFD);
        repeat (5) qstep(0, 1);
        waitVv();
        check("vel0_wrap", vel[QEI_RES-1:0], 16'd5);
        check("pos0_wrap", pos[QEI_RES-1:0], 16'd2);

        for (int i = 0; i < 10000; i++) begin
            r = $urandom_range(0, 99);
            c = $urandom_range(0, NCH - 1);
            if (r < 15) begin
                setStep(c, ($urandom_range(0, 1) == 1) ? 1 : -1);
            end else if (r == 15 && $urandom_range(0, 9) == 0) begin
                qei_a[c] = ~qei_a[c];
                qei_b[c] = ~qei_b[c];
                ph[c] = (ph[c] + 2) % 4;
            end
            wr_valid = ($urandom_range(0, 15) == 0);
            wr_ch    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'($urandom_range(0, NCH - 1));
            case ($urandom_range(0, 3))
                0:       wr_duty = '0;
                1:       wr_duty = '1;
                default: wr_duty = PWM_RES'($urandom);
            endcase
            if ($urandom_range(0, 399) == 0) en = ~en;
            cyc(1);
        end
        wr_valid = 1'b0;
        en = 1'b1;
        cyc(5);

`ifdef MOTOR_ARRAY_WDOG_EN
        wr_ch = 3'd0;
        waitReady();
        wr_duty = 10'd300; wr_valid = 1'b1;
        cyc(1);
        wr_valid = 1'b0;
        repeat (8) waitVv();
        cyc(PERIOD + 2100);
        countHigh(0);
        check("wdog_pwm0_low", hi, 0);
        waitReady();
        wr_duty = 10'd300; wr_valid = 1'b1;
        cyc(1);
        wr_valid = 1'b0;
        cyc(PERIOD + 10);
        countHigh(0);
        check("wdog_pwm0_restored", hi, 300 * PWM_DIV);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
